div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a division (driven by the control unit's DIV_control).
REQ-005 The block SHALL have port a, input, DATA_W bits: dividend (register A output).
REQ-006 The block SHALL have port b, input, DATA_W bits: divisor (register B output).
REQ-007 The block SHALL have port hi, output, DATA_W bits: remainder, feeding the HI register path.
REQ-008 The block SHALL have port lo, output, DATA_W bits: quotient, feeding the LO register path.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle completion pulse (the control unit's divStop).
REQ-011 The block SHALL have port div_zero, output, 1 bit: one-cycle divide-by-zero pulse.

Function
REQ-012 The FSM SHALL have states IDLE, CALC and FIN.
REQ-013 In IDLE, start=1 at an edge SHALL latch a, b and their signs, and move to CALC with the iteration counter at 0.
REQ-014 If b==0 at that start edge, the FSM SHALL stay in IDLE, pulse done=1 and div_zero=1 for the next cycle, and leave hi/lo unchanged.
REQ-015 CALC SHALL perform one restoring shift-subtract step per edge on operand magnitudes, for exactly DATA_W edges, then go to FIN.
REQ-016 The FIN edge SHALL write sign-corrected lo/hi, make done=1 for exactly one cycle, and return to IDLE.
REQ-017 Latency SHALL be fixed: done is high in the cycle after edge DATA_W+1, counting the start edge as edge 0 (edge 33 for DATA_W=32).
REQ-018 busy SHALL be 1 in CALC and FIN, and 0 otherwise.
REQ-019 start SHALL be ignored while busy=1, with no queueing and no effect on the running operation.
REQ-020 hi/lo SHALL hold their last result until the next successful completion or reset; a and b may change freely after the start edge.
REQ-021 Results SHALL satisfy a = lo*b + hi, truncated to DATA_W bits.
REQ-022 In signed mode, quotient sign SHALL be sign(a) xor sign(b), and the remainder SHALL take the sign of a.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0, with no flag raised.
REQ-024 start in the same cycle as done SHALL be accepted, because the FSM is already in IDLE then.

Reset
REQ-025 On reset=1 at an edge, the FSM SHALL go to IDLE, and hi, lo, busy, done and div_zero SHALL all go to 0.
REQ-026 Reset SHALL take priority over start and abort any operation in progress, producing no done pulse.

Configuration
REQ-027 With DIV_SIGNED_EN defined, a and b SHALL be treated as two's complement, giving MIPS div semantics per REQ-022/023.
REQ-028 Without DIV_SIGNED_EN, a and b SHALL be treated as unsigned (divu semantics), with no sign-correction logic synthesised; latency and handshake are unchanged.

Structure
REQ-029 Shared package div_pkg SHALL hold the FSM state enum (IDLE/CALC/FIN) and the DATA_W default constant.
REQ-030 One combinational sub-module, div_step, SHALL implement a single restoring iteration: partial remainder and quotient in, updated values out.

Verification
REQ-031 Scenario: a=100, b=7, start for 1 cycle -> busy for 33 cycles; done=1 in cycle 34; lo=14, hi=2.
REQ-032 Scenario: signed, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-033 Scenario: after a prior result lo=14, hi=2, issue a=5, b=0 -> next cycle done=1 and div_zero=1; busy stays 0; lo=14, hi=2 retained.
REQ-034 Scenario: start a=100, b=7, then pulse start with a=9, b=3 at cycle 10 -> result is still lo=14, hi=2 at the original latency.
REQ-035 Scenario: reset at cycle 15 of a division -> all outputs 0 on the next cycle; no done pulse follows.
REQ-036 Scenario: signed, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and default width.
package div_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] dvs,
    output logic [DATA_W-1:0] rem_nxt,
    output logic [DATA_W-1:0] quo_nxt
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;
    logic            borrow;

    // rem < dvs holds between steps, so the extra top bit of diff is a clean borrow flag.
    assign shifted = {rem, quo[DATA_W-1]};
    assign diff    = shifted - {1'b0, dvs};
    assign borrow  = diff[DATA_W];

    assign rem_nxt = borrow ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
    assign quo_nxt = {quo[DATA_W-2:0], ~borrow};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider with fixed DATA_W+1 cycle latency after the start edge.
// Define DIV_SIGNED_EN for two's-complement (div) semantics; default build is unsigned (divu).
module div_unit
    import div_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              div_zero
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  rem;
    logic [DATA_W-1:0]  quo;
    logic [DATA_W-1:0]  dvs;
    logic [DATA_W-1:0]  rem_nxt;
    logic [DATA_W-1:0]  quo_nxt;
    logic [DATA_W-1:0]  mag_a;
    logic [DATA_W-1:0]  mag_b;
    logic               last;

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // Magnitude of the most negative value wraps to itself, which is the correct unsigned magnitude.
    assign mag_a = a[DATA_W-1] ? -a : a;
    assign mag_b = b[DATA_W-1] ? -b : b;
`else
    assign mag_a = a;
    assign mag_b = b;
`endif

    assign last = (cnt == CNT_W'(DATA_W - 1));
    assign busy = (state != IDLE);

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem     (rem),
        .quo     (quo),
        .dvs     (dvs),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && (b != '0)) state_nxt = CALC;
            CALC:    if (last) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            cnt      <= '0;
`ifdef DIV_SIGNED_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b == '0) begin
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            rem <= '0;
                            quo <= mag_a;
                            dvs <= mag_b;
                            cnt <= '0;
`ifdef DIV_SIGNED_EN
                            neg_q <= a[DATA_W-1] ^ b[DATA_W-1];
                            neg_r <= a[DATA_W-1];
`endif
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + CNT_W'(1);
                end
                FIN: begin
`ifdef DIV_SIGNED_EN
                    lo <= neg_q ? -quo : quo;
                    hi <= neg_r ? -rem : rem;
`else
                    lo <= quo;
                    hi <= rem;
`endif
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
